// File: rtl/bst_update_scheduler.sv
// bst_update_scheduler: funnels mispredict (B) and buffered resolve (A) updates into the BST write port and runs flush walks.
// Optional BST_COALESCE_EN: A merges into queued entries with the same index, B invalidates queued stale entries.
module bst_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int BST_LENGTH = 16384,
  parameter int INDEX_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_pc,
  input  logic [1:0]  a_status,
  input  logic [31:0] a_target,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_pc,
  input  logic [1:0]  b_status,
  input  logic [31:0] b_target,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        wr_en,
  output logic [31:0] wr_pc,
  output logic [1:0]  wr_status,
  output logic [31:0] wr_target
);
  localparam int PW = $clog2(DEPTH);
`ifdef BST_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [31:0] f_pc [DEPTH];
  logic [1:0] f_status [DEPTH];
  logic [31:0] f_target [DEPTH];
  logic [DEPTH-1:0] f_v;
  logic [PW-1:0] rd_ptr, wr_ptr, a_slot, slot;
  logic [PW:0] count;
  logic [INDEX_W:0] idx;
  logic idle, full, b_hs, a_hs, flush_go, pop, push, a_match, a_kill, walk_done;
  assign idle = state == IDLE;
  assign full = count == (PW+1)'(DEPTH);
  assign b_hs = b_valid && b_ready;
  assign a_hs = a_valid && a_ready;
  assign flush_go = idle && flush_req;
  assign pop = idle && !flush_go && !b_hs && count != '0;
  assign push = a_hs && !a_match && !flush_go;
  assign a_kill = COAL && b_hs && a_pc[INDEX_W:1] == b_pc[INDEX_W:1];
  assign walk_done = idx == (INDEX_W+1)'(BST_LENGTH);
  // Scan oldest to youngest so the youngest match wins; a head being popped this edge is not a merge target.
  always_comb begin
    a_match = 1'b0;
    a_slot = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if (COAL && f_v[slot] && f_pc[slot][INDEX_W:1] == a_pc[INDEX_W:1] && !(pop && k == 0)) begin
        a_match = 1'b1;
        a_slot = slot;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb state_nxt = idle ? (flush_req ? FLUSH : IDLE) : (walk_done ? IDLE : FLUSH);
  always_comb begin
    a_ready = idle && (!full || a_match);
    b_ready = idle;
    flush_busy = !idle;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      f_v <= '0;
    end else if (flush_go) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      f_v <= '0;
    end else if (idle) begin
      for (int k = 0; k < DEPTH; k++)
        if (COAL && b_hs && f_pc[k][INDEX_W:1] == b_pc[INDEX_W:1]) f_v[k] <= 1'b0;
      if (pop) f_v[rd_ptr] <= 1'b0;
      if (push) f_v[wr_ptr] <= !a_kill;
      if (a_hs && a_match) f_v[a_slot] <= !a_kill;
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (a_hs) begin
      f_pc[a_match ? a_slot : wr_ptr] <= a_pc;
      f_status[a_match ? a_slot : wr_ptr] <= a_status;
      f_target[a_match ? a_slot : wr_ptr] <= a_target;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= 1'b0;
      wr_pc <= '0;
      wr_status <= '0;
      wr_target <= '0;
      idx <= '0;
    end else if (!idle) begin
      wr_en <= !walk_done;
      idx <= walk_done ? '0 : idx + (INDEX_W+1)'(1);
      if (!walk_done) begin
        wr_pc <= 32'(idx[INDEX_W-1:0]);
        wr_status <= '0;
        wr_target <= '0;
      end
    end else if (b_hs) begin
      wr_en <= 1'b1;
      wr_pc <= b_pc;
      wr_status <= b_status;
      wr_target <= b_target;
    end else if (pop && f_v[rd_ptr]) begin
      wr_en <= 1'b1;
      wr_pc <= f_pc[rd_ptr];
      wr_status <= f_status[rd_ptr];
      wr_target <= f_target[rd_ptr];
    end else begin
      wr_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bst_update_scheduler.sv
// tb_bst_update_scheduler: directed stimulus with a write scoreboard checked by a forked monitor.
module tb_bst_update_scheduler;
  localparam int BST = 16384;
  logic clk = 1'b0, rst_n = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, flush_req = 1'b0;
  logic [31:0] a_pc = '0, a_target = '0, b_pc = '0, b_target = '0;
  logic [1:0] a_status = '0, b_status = '0;
  logic a_ready, b_ready, flush_busy, wr_en;
  logic [31:0] wr_pc, wr_target;
  logic [1:0] wr_status;
  logic [65:0] exp_q [$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bst_update_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc), .a_status(a_status), .a_target(a_target),
    .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc), .b_status(b_status), .b_target(b_target),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .wr_en(wr_en), .wr_pc(wr_pc), .wr_status(wr_status), .wr_target(wr_target)
  );
  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wr(input logic [31:0] pc, input logic [1:0] st, input logic [31:0] tg);
    exp_q.push_back({pc, st, tg});
  endtask
  initial begin
    int busy_bad;
    fork
      forever begin
        @(negedge clk);
        if (wr_en === 1'b1) begin
          chk("wr_expected", 66'(exp_q.size() != 0), 66'd1);
          if (exp_q.size() != 0) chk("wr_payload", {wr_pc, wr_status, wr_target}, exp_q.pop_front());
        end
      end
    join_none
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_wr_en", 66'(wr_en), 66'd0);
    chk("rst_flags", 66'({a_ready, b_ready, flush_busy}), 66'b110);
    chk("rst_payload", {wr_pc, wr_status, wr_target}, 66'd0);
    rst_n = 1'b1;
    step();
    // single A update: two-edge latency, no bypass
    a_valid = 1; a_pc = 32'h104; a_status = 2; a_target = 32'h200;
    expect_wr(32'h104, 2, 32'h200);
    step(); a_valid = 0;
    chk("t1_no_bypass", 66'(wr_en), 66'd0);
    step(); chk("t1_issue", 66'({wr_en, wr_pc}), 66'({1'b1, 32'h104}));
    step(); chk("t1_idle", 66'(wr_en), 66'd0);
    // A and B together: B first
    a_valid = 1; a_pc = 32'h10; a_status = 1; a_target = 32'h1010;
    b_valid = 1; b_pc = 32'h20; b_status = 3; b_target = 32'h2020;
    expect_wr(32'h20, 3, 32'h2020);
    expect_wr(32'h10, 1, 32'h1010);
    step(); a_valid = 0; b_valid = 0;
    chk("t2_b_first", 66'({wr_en, wr_pc}), 66'({1'b1, 32'h20}));
    step(); chk("t2_a_second", 66'({wr_en, wr_pc}), 66'({1'b1, 32'h10}));
    step();
    // fill FIFO while B blocks pops
    for (int i = 0; i < 6; i++) begin
      int ai;
      ai = i < 4 ? i : 4;
      b_valid = 1; b_pc = 32'h1000 + 32'(i * 4); b_status = 2'(i); b_target = 32'h900 + 32'(i);
      expect_wr(b_pc, b_status, b_target);
      a_valid = 1; a_pc = 32'h100 + 32'(ai * 4); a_status = 2'(ai); a_target = 32'h300 + 32'(ai);
      step();
      if (i == 3) chk("t3_full", 66'(a_ready), 66'd0);
    end
    chk("t3_still_full", 66'(a_ready), 66'd0);
    b_valid = 0;
    for (int ai = 0; ai < 5; ai++) expect_wr(32'h100 + 32'(ai * 4), 2'(ai), 32'h300 + 32'(ai));
    step(); chk("t3_ready_back", 66'(a_ready), 66'd1);
    step(); a_valid = 0;
    repeat (6) step();
    chk("t3_drained", 66'(wr_en), 66'd0);
    // flush with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      b_valid = 1; b_pc = 32'h5000 + 32'(i * 4); b_status = 1; b_target = 32'h55;
      expect_wr(b_pc, b_status, b_target);
      a_valid = 1; a_pc = 32'h600 + 32'(i * 4); a_status = 3; a_target = 32'h66;
      step();
    end
    b_valid = 0; a_valid = 0; flush_req = 1;
    for (int k = 0; k < BST; k++) expect_wr(32'(k), 0, 0);
    step(); flush_req = 0;
    chk("t4_enter", 66'({flush_busy, a_ready, b_ready, wr_en}), 66'b1000);
    a_valid = 1; b_valid = 1;
    busy_bad = 0;
    for (int k = 0; k < BST; k++) begin
      step();
      if (k == 10) flush_req = 1;
      if (k == 20) flush_req = 0;
      if (!flush_busy || a_ready || b_ready || !wr_en) busy_bad++;
    end
    a_valid = 0; b_valid = 0;
    chk("t4_busy_hold", 66'(busy_bad), 66'd0);
    chk("t4_last_idx", 66'(wr_pc), 66'(BST - 1));
    step(); chk("t4_exit", 66'({flush_busy, a_ready, b_ready, wr_en}), 66'b0110);
    step();
    // B on flush-entry edge, then reset mid-walk
    b_valid = 1; b_pc = 32'h7000; b_status = 2; b_target = 32'h7777; flush_req = 1;
    expect_wr(32'h7000, 2, 32'h7777);
    for (int k = 0; k <= 100; k++) expect_wr(32'(k), 0, 0);
    step(); b_valid = 0; flush_req = 0;
    chk("t5_b_on_entry", 66'({wr_en, wr_pc, flush_busy}), 66'({1'b1, 32'h7000, 1'b1}));
    repeat (101) step();
    chk("t5_idx100", 66'({wr_en, wr_pc}), 66'({1'b1, 32'd100}));
    @(negedge clk); #1 rst_n = 1'b0; #1;
    chk("t5_rst_out", {wr_pc, wr_status, wr_target}, 66'd0);
    chk("t5_rst_flags", 66'({a_ready, b_ready, flush_busy, wr_en}), 66'b1100);
    step(); rst_n = 1'b1;
    repeat (3) step();
    chk("t5_no_resume", 66'({a_ready, b_ready, flush_busy, wr_en}), 66'b1100);
`ifdef BST_COALESCE_EN
    b_valid = 1; b_pc = 32'h2000; b_status = 1; b_target = 32'h0;
    expect_wr(b_pc, b_status, b_target);
    a_valid = 1; a_pc = 32'h40; a_status = 1; a_target = 32'h44;
    step();
    b_pc = 32'h2004;
    expect_wr(b_pc, b_status, b_target);
    a_status = 3; a_target = 32'h48;
    step(); b_valid = 0; a_valid = 0;
    expect_wr(32'h40, 3, 32'h48);
    repeat (3) step();
    b_valid = 1; b_pc = 32'h3000; b_status = 1; b_target = 32'h0;
    expect_wr(b_pc, b_status, b_target);
    a_valid = 1; a_pc = 32'h80; a_status = 1; a_target = 32'h81;
    step(); a_valid = 0;
    b_pc = 32'h80; b_status = 2; b_target = 32'h88;
    expect_wr(b_pc, b_status, b_target);
    step(); b_valid = 0;
    repeat (3) step();
    chk("c_no_stale", 66'(wr_en), 66'd0);
`endif
    repeat (3) step();
    chk("queue_empty", 66'(exp_q.size()), 66'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
